// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit SAP computer: a 6-state one-hot T-ring plus
// opcode decode that produces the per-cycle load/enable strobes for the datapath.
module control_sequencer #(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [OPW-1:0] opcode,
  output logic [5:0]     t_state,
  output logic           pc_inc,
  output logic           pc_en,
  output logic           pc_load,
  output logic           mar_load,
  output logic           ram_en,
  output logic           ir_load,
  output logic           ir_en,
  output logic           a_load,
  output logic           a_en,
  output logic           b_load,
  output logic           alu_en,
  output logic           sub,
  output logic           out_load,
  output logic           halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_JMP = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'b1110);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'b1111);

  tstate_e t_q, t_d;
  logic    halted_q, halted_d;

  // HLT takes effect on the edge ending T4, which leaves the ring parked in T5.
  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    if (en && !halted_q) begin
      if (t_q == T4 && opcode == OP_HLT) halted_d = 1'b1;
      case (t_q)
        T1:      t_d = T2;
        T2:      t_d = T3;
        T3:      t_d = T4;
        T4:      t_d = T5;
        T5:      t_d = T6;
        T6:      t_d = T1;
        default: t_d = T1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q      <= T1;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  assign t_state = t_q;
  assign halted  = halted_q;

  // Strobes are combinational so the target register samples them on the edge ending the state.
  always_comb begin
    pc_inc   = 1'b0;
    pc_en    = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    ram_en   = 1'b0;
    ir_load  = 1'b0;
    ir_en    = 1'b0;
    a_load   = 1'b0;
    a_en     = 1'b0;
    b_load   = 1'b0;
    alu_en   = 1'b0;
    sub      = 1'b0;
    out_load = 1'b0;
    if (en && !rst && !halted_q) begin
      case (t_q)
        T1: begin pc_en = 1'b1; mar_load = 1'b1; end
        T2: pc_inc = 1'b1;
        T3: begin ram_en = 1'b1; ir_load = 1'b1; end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin ir_en = 1'b1; mar_load = 1'b1; end
            OP_JMP:                 begin ir_en = 1'b1; pc_load = 1'b1; end
            OP_OUT:                 begin a_en = 1'b1; out_load = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:         begin ram_en = 1'b1; a_load = 1'b1; end
            OP_ADD, OP_SUB: begin ram_en = 1'b1; b_load = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_en = 1'b1;
            a_load = 1'b1;
            sub    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues hand-computed expected
// state/strobe vectors, a negedge monitor pops and compares them.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic pc_inc, pc_en, pc_load, mar_load, ram_en, ir_load, ir_en;
  logic a_load, a_en, b_load, alu_en, sub, out_load, halted;

  control_sequencer #(.OPW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .t_state(t_state),
    .pc_inc(pc_inc), .pc_en(pc_en), .pc_load(pc_load), .mar_load(mar_load),
    .ram_en(ram_en), .ir_load(ir_load), .ir_en(ir_en), .a_load(a_load),
    .a_en(a_en), .b_load(b_load), .alu_en(alu_en), .sub(sub),
    .out_load(out_load), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam logic [12:0] PC_INC   = 13'd1 << 12;
  localparam logic [12:0] PC_EN    = 13'd1 << 11;
  localparam logic [12:0] PC_LOAD  = 13'd1 << 10;
  localparam logic [12:0] MAR_LOAD = 13'd1 << 9;
  localparam logic [12:0] RAM_EN   = 13'd1 << 8;
  localparam logic [12:0] IR_LOAD  = 13'd1 << 7;
  localparam logic [12:0] IR_EN    = 13'd1 << 6;
  localparam logic [12:0] A_LOAD   = 13'd1 << 5;
  localparam logic [12:0] A_EN     = 13'd1 << 4;
  localparam logic [12:0] B_LOAD   = 13'd1 << 3;
  localparam logic [12:0] ALU_EN   = 13'd1 << 2;
  localparam logic [12:0] SUB      = 13'd1 << 1;
  localparam logic [12:0] OUT_LOAD = 13'd1 << 0;
  localparam logic [12:0] NONE     = 13'd0;

  localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;

  typedef struct {
    string       nm;
    logic [5:0]  t;
    logic [12:0] s;
    logic        h;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  wire [12:0] act = {pc_inc, pc_en, pc_load, mar_load, ram_en, ir_load, ir_en,
                     a_load, a_en, b_load, alu_en, sub, out_load};

  always @(negedge clk) begin
    checks++;
    assert ($countones({pc_en, ram_en, ir_en, a_en, alu_en}) <= 1)
    else begin
      failures++;
      $display("FAIL bus_drivers: got %b, required at most one set",
               {pc_en, ram_en, ir_en, a_en, alu_en});
    end
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (t_state !== e.t || act !== e.s || halted !== e.h) begin
        failures++;
        $display("FAIL %s: got t=%b s=%b h=%b, required t=%b s=%b h=%b",
                 e.nm, t_state, act, halted, e.t, e.s, e.h);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [5:0] t, input logic [12:0] s, input logic h);
    exp_t e;
    e.nm = nm; e.t = t; e.s = s; e.h = h;
    q.push_back(e);
  endtask

  // Queue this cycle's expectation, then move to the next cycle.
  task automatic chk(input string nm, input logic [5:0] t, input logic [12:0] s, input logic h);
    push(nm, t, s, h);
    cyc();
  endtask

  task automatic instr(input logic [3:0] op, input logic [12:0] s4, s5, s6, input string nm);
    opcode = op;
    chk({nm, "_t1"}, T1, PC_EN | MAR_LOAD, 1'b0);
    chk({nm, "_t2"}, T2, PC_INC, 1'b0);
    chk({nm, "_t3"}, T3, RAM_EN | IR_LOAD, 1'b0);
    chk({nm, "_t4"}, T4, s4, 1'b0);
    chk({nm, "_t5"}, T5, s5, 1'b0);
    chk({nm, "_t6"}, T6, s6, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; opcode = 4'b0000;
    cyc();
    chk("reset", T1, NONE, 1'b0);
    rst = 1'b0;

    instr(4'b0000, IR_EN | MAR_LOAD, RAM_EN | A_LOAD, NONE, "lda");
    instr(4'b0010, IR_EN | MAR_LOAD, RAM_EN | B_LOAD, ALU_EN | A_LOAD | SUB, "sub");
    instr(4'b0101, NONE, NONE, NONE, "nop5");

    // Pause in T3 of an LDA
    opcode = 4'b0000;
    chk("pz_t1", T1, PC_EN | MAR_LOAD, 1'b0);
    chk("pz_t2", T2, PC_INC, 1'b0);
    en = 1'b0;
    repeat (4) chk("pz_hold", T3, NONE, 1'b0);
    en = 1'b1;
    chk("pz_t3", T3, RAM_EN | IR_LOAD, 1'b0);
    chk("pz_t4", T4, IR_EN | MAR_LOAD, 1'b0);
    chk("pz_t5", T5, RAM_EN | A_LOAD, 1'b0);
    chk("pz_t6", T6, NONE, 1'b0);

    instr(4'b0001, IR_EN | MAR_LOAD, RAM_EN | B_LOAD, ALU_EN | A_LOAD, "add");

    // ADD interrupted by reset in the middle of T5
    opcode = 4'b0001;
    chk("addr_t1", T1, PC_EN | MAR_LOAD, 1'b0);
    chk("addr_t2", T2, PC_INC, 1'b0);
    chk("addr_t3", T3, RAM_EN | IR_LOAD, 1'b0);
    chk("addr_t4", T4, IR_EN | MAR_LOAD, 1'b0);
    #1 rst = 1'b1;
    chk("add_rst_mid", T1, NONE, 1'b0);
    rst = 1'b0;

    instr(4'b0011, IR_EN | PC_LOAD, NONE, NONE, "jmp");
    instr(4'b1110, A_EN | OUT_LOAD, NONE, NONE, "out");

    // Opcode wiggling during fetch must not matter
    opcode = 4'b1111;
    chk("fw_t1", T1, PC_EN | MAR_LOAD, 1'b0);
    opcode = 4'b0011;
    chk("fw_t2", T2, PC_INC, 1'b0);
    opcode = 4'b1110;
    chk("fw_t3", T3, RAM_EN | IR_LOAD, 1'b0);
    opcode = 4'b0001;
    chk("fw_t4", T4, IR_EN | MAR_LOAD, 1'b0);
    chk("fw_t5", T5, RAM_EN | B_LOAD, 1'b0);
    chk("fw_t6", T6, ALU_EN | A_LOAD, 1'b0);

    // Halt, stay frozen, then reset out of it
    opcode = 4'b1111;
    chk("hlt_t1", T1, PC_EN | MAR_LOAD, 1'b0);
    chk("hlt_t2", T2, PC_INC, 1'b0);
    chk("hlt_t3", T3, RAM_EN | IR_LOAD, 1'b0);
    chk("hlt_t4", T4, NONE, 1'b0);
    repeat (12) chk("hlt_hold", T5, NONE, 1'b1);
    en = 1'b0;
    chk("hlt_en0", T5, NONE, 1'b1);
    en = 1'b1;
    rst = 1'b1;
    chk("hlt_rst", T1, NONE, 1'b0);
    rst = 1'b0;

    instr(4'b0000, IR_EN | MAR_LOAD, RAM_EN | A_LOAD, NONE, "lda2");

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

SAP-style microcode sequencer for the 8-bit computer. Steps a 6-state T-cycle ring, decodes the 4-bit opcode held in the instruction register, and drives the per-cycle load/enable strobes that the datapath registers (PC, MAR, IR, A, B, OUT) sample on the rising clock edge. It sits directly upstream of every `register` instance and supplies its `load` input.

## Interface

- `OPW`, default 4: opcode width; only the listed encodings are decoded.
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  run enable; 0 freezes the T-ring and gates all strobes to 0.
- `opcode`  input  OPW  IR[7:4], valid from T4 onward.
- `t_state`  output  6  one-hot current T-state, T1 = 6'b000001.
- `pc_inc`  output  1  program counter increment.
- `pc_en`  output  1  PC drives bus.
- `pc_load`  output  1  PC loads from bus (jump).
- `mar_load`  output  1  MAR loads from bus.
- `ram_en`  output  1  RAM drives bus.
- `ir_load`  output  1  IR loads from bus.
- `ir_en`  output  1  IR[3:0] drives bus.
- `a_load`, `a_en`  output  1 each  A register load / drive bus.
- `b_load`  output  1  B register load.
- `alu_en`  output  1  ALU result drives bus.
- `sub`  output  1  ALU subtract select.
- `out_load`  output  1  output register load.
- `halted`  output  1  sticky halt flag.

## Operation

- State: one-hot ring T1→T2→…→T6→T1, plus `halted` flag. Fixed 6 states per instruction, no early exit.
- Strobes are combinational from (t_state, opcode, halted, en, rst); any strobe not listed is 0.
- Fetch, all opcodes: T1 `pc_en`,`mar_load`; T2 `pc_inc`; T3 `ram_en`,`ir_load`.
- LDA 0000: T4 `ir_en`,`mar_load`; T5 `ram_en`,`a_load`; T6 none.
- ADD 0001: T4 `ir_en`,`mar_load`; T5 `ram_en`,`b_load`; T6 `alu_en`,`a_load`.
- SUB 0010: as ADD, plus `sub` in T6 only.
- JMP 0011: T4 `ir_en`,`pc_load`; T5, T6 none.
- OUT 1110: T4 `a_en`,`out_load`; T5, T6 none.
- HLT 1111: no strobes; `halted` sets on the rising edge ending T4.
- Any other opcode: NOP (T4–T6 no strobes).
- At most one bus driver (`pc_en`,`ram_en`,`ir_en`,`a_en`,`alu_en`) asserted in any state; a bench assertion checks this.
- `halted`=1: ring frozen at T5, all strobes 0; cleared only by `rst`.
- `en`=0: ring holds, all strobes 0, `halted` unchanged; resumes in same T-state when `en` returns to 1.

## Timing

- Reset (async, immediate): `t_state`=T1, `halted`=0; while `rst`=1 all strobes forced 0 regardless of state.
- First rising edge after `rst` falls with `en`=1: T1 strobes were visible during the preceding low-reset portion of that cycle, so PC→MAR occurs on that edge; ring then advances to T2.
- Each strobe is asserted for exactly one clock cycle and sampled by the target register on the edge that ends that state.
- Instruction latency: 6 cycles; instruction N+1 fetch T1 follows T6 on the next edge.
- `opcode` is sampled combinationally only in T4–T6; changes during T1–T3 have no effect.
- Reset mid-instruction: ring returns to T1 asynchronously, in-flight strobes drop the same instant, no partial-state recovery.
- `en` and `rst` both high: reset dominates.

## Test plan

- Reset then run: `rst`=1 for 5 time units, release with `en`=1 → `t_state` cycles 000001,000010,…,100000,000001; `halted`=0; all strobes 0 while `rst`=1.
- Fetch + LDA: opcode=4'b0000 → T1 `pc_en`&`mar_load`, T2 `pc_inc`, T3 `ram_en`&`ir_load`, T4 `ir_en`&`mar_load`, T5 `ram_en`&`a_load`, T6 no strobes.
- SUB: opcode=4'b0010 → T5 `b_load`=1; T6 `alu_en`=`a_load`=`sub`=1; `sub`=0 in every other state.
- HLT: opcode=4'b1111 → after T4 edge `halted`=1, `t_state` stuck at 6'b010000 for 10+ cycles, all strobes 0; assert `rst` → `halted`=0, `t_state`=T1.
- Pause: drop `en` in T3 for 4 cycles → `t_state` stays 6'b000100, `ir_load`=0 throughout; raise `en` → `ir_load`=1 for one cycle then T4.
- Mid-op reset and illegal opcode: opcode=4'b0101 → T4–T6 all strobes 0; assert `rst` during T5 of an ADD → `t_state`=T1 and `b_load`=0 immediately, before the next edge.
